arashi_mt_cache: RTL and testbench

//   Multi-thread write cache: per-thread FIFOs buffer writes from THREAD_NUM threads; an arbiter

---
 rtl/arashi_pkg.sv | 18 +
 rtl/arashi_fifo.sv | 71 +++++++
 rtl/arashi_mt_cache.sv | 158 +++++++++++++++
 tb/tb_arashi_mt_cache.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arashi_pkg.sv
// Shared types and sizing helpers for the arashi multi-thread write cache.
package arashi_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int THREAD_NUM_WIDTH_MIN = 1;
    localparam int THREAD_NUM_WIDTH_MAX = 4;
    localparam int DEPTH_WIDTH_MIN      = 1;
    localparam int DEPTH_WIDTH_MAX      = 6;

    function automatic int pow2(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/arashi_fifo.sv
// Per-thread synchronous FIFO. full/empty are registered; empty deliberately lags pushes by
// one edge so a freshly written word becomes a grant candidate only on the following cycle.
module arashi_fifo
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = pow2(DEPTH_WIDTH);

    typedef logic [DEPTH_WIDTH:0] ptr_t;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t occ_cur, occ_next;
    logic full_q, full_d;
    logic avail_q, avail_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        occ_cur  = wr_ptr_q - rd_ptr_q;
        occ_next = wr_ptr_d - rd_ptr_d;
        full_d   = (occ_next == ptr_t'(DEPTH));
        // Availability counts only words already resident before this edge, minus this edge's pop.
        avail_d  = ((occ_cur - ptr_t'(pop)) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            avail_q  <= avail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
    assign full  = full_q;
    assign empty = !avail_q;

endmodule

// File: rtl/arashi_mt_cache.sv
// Multi-thread write cache: per-thread FIFOs drained one word per cycle through an arbiter
// into a valid/ready output register tagged with the source thread id.
module arashi_mt_cache
    import arashi_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2,
    parameter int DEPTH_WIDTH      = 2,
    parameter int ARB_MODE         = 0,
    localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [THREAD_NUM-1:0]            w_ena,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] data_in,
    output logic [THREAD_NUM-1:0]            full,
    output logic [THREAD_NUM-1:0]            avail,
    output logic [THREAD_NUM-1:0]            ovf,
    input  logic [THREAD_NUM-1:0]            ovf_clr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [THREAD_NUM_WIDTH-1:0]      out_tid
);

    generate
        if (THREAD_NUM_WIDTH < THREAD_NUM_WIDTH_MIN || THREAD_NUM_WIDTH > THREAD_NUM_WIDTH_MAX) begin : g_bad_tnw
            $error("arashi_mt_cache: THREAD_NUM_WIDTH must be in 1..4");
        end
        if (DEPTH_WIDTH < DEPTH_WIDTH_MIN || DEPTH_WIDTH > DEPTH_WIDTH_MAX) begin : g_bad_depth
            $error("arashi_mt_cache: DEPTH_WIDTH must be in 1..6");
        end
        if (ARB_MODE != int'(ARB_RR) && ARB_MODE != int'(ARB_FIXED)) begin : g_bad_arb
            $error("arashi_mt_cache: ARB_MODE must be 0 or 1");
        end
    endgenerate

    logic [THREAD_NUM-1:0]       fifo_full;
    logic [THREAD_NUM-1:0]       fifo_empty;
    logic [THREAD_NUM-1:0]       avail_vec;
    logic [THREAD_NUM-1:0]       push;
    logic [THREAD_NUM-1:0]       pop;
    logic [DATA_WIDTH-1:0]       head [THREAD_NUM];

    logic [THREAD_NUM_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [THREAD_NUM_WIDTH-1:0] rr_idx;
    logic [THREAD_NUM_WIDTH-1:0] rr_grant;
    logic [THREAD_NUM_WIDTH-1:0] fix_grant;
    logic [THREAD_NUM_WIDTH-1:0] grant;
    logic                        rr_found;
    logic                        fix_found;
    logic                        any_avail;
    logic                        load;
    logic                        grant_fire;

    logic                        out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [THREAD_NUM_WIDTH-1:0] out_tid_q, out_tid_d;
    logic [THREAD_NUM-1:0]       ovf_q, ovf_d;

    generate
        for (genvar i = 0; i < THREAD_NUM; i++) begin : g_fifo
            arashi_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH_WIDTH(DEPTH_WIDTH)
            ) u_fifo (
                .clk  (clk),
                .rstn (rstn),
                .push (push[i]),
                .pop  (pop[i]),
                .din  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
                .dout (head[i]),
                .full (fifo_full[i]),
                .empty(fifo_empty[i])
            );
        end
    endgenerate

    assign avail_vec = ~fifo_empty;

    // A push against the registered full flag is dropped even if that FIFO pops this cycle.
    always_comb begin
        push  = w_ena & ~fifo_full;
        ovf_d = (ovf_q & ~ovf_clr) | (w_ena & fifo_full);
    end

    always_comb begin
        rr_idx    = rr_ptr_q;
        rr_grant  = rr_ptr_q;
        rr_found  = 1'b0;
        for (int k = 1; k <= THREAD_NUM; k++) begin
            rr_idx = rr_ptr_q + THREAD_NUM_WIDTH'(k);
            if (!rr_found && avail_vec[rr_idx]) begin
                rr_grant = rr_idx;
                rr_found = 1'b1;
            end
        end

        fix_grant = '0;
        fix_found = 1'b0;
        for (int k = 0; k < THREAD_NUM; k++) begin
            if (!fix_found && avail_vec[k]) begin
                fix_grant = THREAD_NUM_WIDTH'(k);
                fix_found = 1'b1;
            end
        end

        grant      = (ARB_MODE == int'(ARB_FIXED)) ? fix_grant : rr_grant;
        any_avail  = |avail_vec;
        load       = !out_valid_q || out_ready;
        grant_fire = load && any_avail;

        pop = '0;
        if (grant_fire) begin
            pop[grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tid_d   = out_tid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = any_avail;
            if (any_avail) begin
                out_data_d = head[grant];
                out_tid_d  = grant;
                rr_ptr_d   = grant;
            end
        end
    end

    // Pointer resets to the last thread so thread 0 is the first round-robin candidate.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q    <= '1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
            ovf_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tid_q   <= out_tid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign full      = fifo_full;
    assign avail     = avail_vec;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tid   = out_tid_q;

endmodule

// File: tb/tb_arashi_mt_cache.sv
// Directed self-checking bench for arashi_mt_cache; a round-robin and a fixed-priority
// instance share every input so arbitration orders can be compared on the same stimulus.
module tb_arashi_mt_cache;

    logic         clk;
    logic         rstn;
    logic [3:0]   w_ena;
    logic [127:0] data_in;
    logic [3:0]   ovf_clr;
    logic         out_ready;

    logic [3:0]   rr_full, rr_avail, rr_ovf;
    logic         rr_out_valid;
    logic [31:0]  rr_out_data;
    logic [1:0]   rr_out_tid;

    logic [3:0]   fx_full, fx_avail, fx_ovf;
    logic         fx_out_valid;
    logic [31:0]  fx_out_data;
    logic [1:0]   fx_out_tid;

    int checks;
    int failures;

    arashi_mt_cache #(.DATA_WIDTH(32), .THREAD_NUM_WIDTH(2), .DEPTH_WIDTH(2), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rstn(rstn), .w_ena(w_ena), .data_in(data_in),
        .full(rr_full), .avail(rr_avail), .ovf(rr_ovf), .ovf_clr(ovf_clr),
        .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_data(rr_out_data), .out_tid(rr_out_tid)
    );

    arashi_mt_cache #(.DATA_WIDTH(32), .THREAD_NUM_WIDTH(2), .DEPTH_WIDTH(2), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rstn(rstn), .w_ena(w_ena), .data_in(data_in),
        .full(fx_full), .avail(fx_avail), .ovf(fx_ovf), .ovf_clr(ovf_clr),
        .out_valid(fx_out_valid), .out_ready(out_ready),
        .out_data(fx_out_data), .out_tid(fx_out_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ena, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input logic [3:0] clr, input logic rdy);
        w_ena     = ena;
        data_in   = {d3, d2, d1, d0};
        ovf_clr   = clr;
        out_ready = rdy;
    endtask

    task automatic applyReset();
        rstn = 1'b0;
        applyStimulus(4'hF, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 4'h0, 1'b1);
        tick();
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        rstn = 1'b1;
    endtask

    function automatic logic [31:0] wd(input int t, input int w);
        return 32'h1000_0000 + 32'(t << 8) + 32'(w);
    endfunction

    int rr_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b1;
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();

        // Reset with all write strobes active: nothing may survive.
        applyReset();
        checkOutput("rst_full",      32'(rr_full),      32'h0);
        checkOutput("rst_avail",     32'(rr_avail),     32'h0);
        checkOutput("rst_ovf",       32'(rr_ovf),       32'h0);
        checkOutput("rst_valid",     32'(rr_out_valid), 32'h0);
        checkOutput("rst_data",      rr_out_data,       32'h0);
        checkOutput("rst_tid",       32'(rr_out_tid),   32'h0);
        checkOutput("rst_fx_valid",  32'(fx_out_valid), 32'h0);
        tick();
        checkOutput("rst_avail_post", 32'(rr_avail),    32'h0);

        // Single write: out_valid appears two edges after the write edge.
        applyStimulus(4'b0100, 32'h0, 32'h0, 32'hA5A5_0002, 32'h0, 4'h0, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("lat_e0_valid", 32'(rr_out_valid), 32'h0);
        checkOutput("lat_e0_avail", 32'(rr_avail),     32'h0);
        tick();
        checkOutput("lat_e1_valid", 32'(rr_out_valid), 32'h0);
        checkOutput("lat_e1_avail", 32'(rr_avail),     32'h4);
        tick();
        checkOutput("lat_e2_valid", 32'(rr_out_valid), 32'h1);
        checkOutput("lat_e2_tid",   32'(rr_out_tid),   32'h2);
        checkOutput("lat_e2_data",  rr_out_data,       32'hA5A5_0002);
        checkOutput("lat_e2_avail", 32'(rr_avail),     32'h0);
        tick();
        checkOutput("lat_e3_valid", 32'(rr_out_valid), 32'h0);

        // Two words per thread, drained by both arbitration modes.
        applyReset();
        applyStimulus(4'hF, wd(0, 0), wd(1, 0), wd(2, 0), wd(3, 0), 4'h0, 1'b1);
        tick();
        applyStimulus(4'hF, wd(0, 1), wd(1, 1), wd(2, 1), wd(3, 1), 4'h0, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("arb_pre_valid_rr", 32'(rr_out_valid), 32'h0);
        checkOutput("arb_pre_valid_fx", 32'(fx_out_valid), 32'h0);
        for (int n = 0; n < 8; n++) begin
            tick();
            checkOutput($sformatf("rr_valid_%0d", n), 32'(rr_out_valid), 32'h1);
            checkOutput($sformatf("rr_tid_%0d", n),   32'(rr_out_tid),   32'(rr_seq[n]));
            checkOutput($sformatf("rr_data_%0d", n),  rr_out_data,       wd(rr_seq[n], n / 4));
            checkOutput($sformatf("fx_tid_%0d", n),   32'(fx_out_tid),   32'(n / 2));
            checkOutput($sformatf("fx_data_%0d", n),  fx_out_data,       wd(n / 2, n % 2));
        end
        tick();
        checkOutput("arb_end_valid_rr", 32'(rr_out_valid), 32'h0);
        checkOutput("arb_end_valid_fx", 32'(fx_out_valid), 32'h0);

        // Park a word in the output register, then overfill thread 1.
        applyStimulus(4'b0001, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick();
        tick();
        checkOutput("ovf_park_valid", 32'(rr_out_valid), 32'h1);
        checkOutput("ovf_park_data",  rr_out_data,       32'h3000_0000);
        for (int w = 0; w < 5; w++) begin
            applyStimulus(4'b0010, 32'h0, 32'h2000_0000 + 32'(w), 32'h0, 32'h0, 4'h0, 1'b0);
            tick();
            checkOutput($sformatf("ovf_full_%0d", w), 32'(rr_full[1]), (w >= 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("ovf_flag_%0d", w), 32'(rr_ovf[1]),  (w >= 4) ? 32'h1 : 32'h0);
        end
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("ovf_hold_data", rr_out_data, 32'h3000_0000);
        tick();
        checkOutput("ovf_drain_full", 32'(rr_full[1]), 32'h0);
        for (int w = 0; w < 4; w++) begin
            if (w > 0) tick();
            checkOutput($sformatf("ovf_drain_valid_%0d", w), 32'(rr_out_valid), 32'h1);
            checkOutput($sformatf("ovf_drain_tid_%0d", w),   32'(rr_out_tid),   32'h1);
            checkOutput($sformatf("ovf_drain_data_%0d", w),  rr_out_data,       32'h2000_0000 + 32'(w));
        end
        tick();
        checkOutput("ovf_drain_end", 32'(rr_out_valid), 32'h0);
        checkOutput("ovf_sticky",    32'(rr_ovf),       32'h2);
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0010, 1'b1);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("ovf_cleared",   32'(rr_ovf),       32'h0);

        // Backpressure for three cycles in the middle of a thread 3 stream.
        for (int w = 0; w < 4; w++) begin
            applyStimulus(4'b1000, 32'h0, 32'h0, 32'h0, 32'h4000_0000 + 32'(w), 4'h0, 1'b0);
            tick();
        end
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("bp_w0_valid", 32'(rr_out_valid), 32'h1);
        checkOutput("bp_w0_data",  rr_out_data,       32'h4000_0000);
        checkOutput("bp_w0_tid",   32'(rr_out_tid),   32'h3);
        tick();
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("bp_w1_data",  rr_out_data,       32'h4000_0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("bp_stall_valid_%0d", c), 32'(rr_out_valid), 32'h1);
            checkOutput($sformatf("bp_stall_data_%0d", c),  rr_out_data,       32'h4000_0001);
            checkOutput($sformatf("bp_stall_tid_%0d", c),   32'(rr_out_tid),   32'h3);
        end
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        tick();
        checkOutput("bp_w2_data",  rr_out_data,       32'h4000_0002);
        tick();
        checkOutput("bp_w3_data",  rr_out_data,       32'h4000_0003);
        tick();
        checkOutput("bp_end_valid", 32'(rr_out_valid), 32'h0);

        // Reset while three words sit in thread 2 and the output register is full.
        for (int w = 0; w < 4; w++) begin
            applyStimulus(4'b0100, 32'h0, 32'h0, 32'h5000_0000 + 32'(w), 32'h0, 4'h0, 1'b0);
            tick();
        end
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("mrst_pre_valid", 32'(rr_out_valid), 32'h1);
        checkOutput("mrst_pre_avail", 32'(rr_avail),     32'h4);
        rstn = 1'b0;
        tick();
        checkOutput("mrst_valid", 32'(rr_out_valid), 32'h0);
        checkOutput("mrst_data",  rr_out_data,       32'h0);
        checkOutput("mrst_tid",   32'(rr_out_tid),   32'h0);
        checkOutput("mrst_avail", 32'(rr_avail),     32'h0);
        checkOutput("mrst_full",  32'(rr_full),      32'h0);
        rstn = 1'b1;
        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("mrst_quiet_%0d", c), 32'(rr_out_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
